// File: rtl/branch_tag_allocator.sv
// rtl/branch_tag_allocator.sv - circular branch tag ring with decode allocation, resolve retirement and mispredict redirect
module branch_tag_allocator #(
  parameter  int DECODE_WIDTH  = 2,
  parameter  int MAX_BRANCH_IF = 4,
  parameter  int RESOLVE_PORTS = 2,
  localparam int TAG_BITS      = $clog2(MAX_BRANCH_IF),
  localparam int CNT_BITS      = TAG_BITS + 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DECODE_WIDTH-1:0]           dec_valid_i,
  input  logic [DECODE_WIDTH-1:0]           dec_is_branch_i,
  output logic                              dec_ready_o,
  output logic [DECODE_WIDTH*TAG_BITS-1:0]  alloc_tag_o,
  input  logic [RESOLVE_PORTS-1:0]          res_valid_i,
  input  logic [RESOLVE_PORTS*TAG_BITS-1:0] res_tag_i,
  input  logic [RESOLVE_PORTS-1:0]          res_mispredict_i,
  input  logic [RESOLVE_PORTS*32-1:0]       res_target_i,
  input  logic                              ext_flush_i,
  output logic                              flush_o,
  output logic [31:0]                       flush_pc_o,
  output logic [TAG_BITS-1:0]               flush_tag_o,
  output logic [CNT_BITS-1:0]               inflight_o,
  output logic                              full_o
);

  logic [TAG_BITS-1:0]      r_head;
  logic [TAG_BITS-1:0]      r_tail;
  logic [CNT_BITS-1:0]      r_count;
  logic [MAX_BRANCH_IF-1:0] r_done;
  logic                     r_flush;
  logic [31:0]              r_flush_pc;
  logic [TAG_BITS-1:0]      r_flush_tag;

  int                            w_nb;
  logic                          w_ready;
  logic                          w_fire;
  logic [TAG_BITS-1:0]           w_run;
  logic [DECODE_WIDTH*TAG_BITS-1:0] w_alloc_tag;

  logic [TAG_BITS-1:0]      w_res_tag;
  logic [TAG_BITS-1:0]      w_res_age;
  logic [MAX_BRANCH_IF-1:0] w_done_set;
  logic                     w_mis_valid;
  logic [TAG_BITS-1:0]      w_mis_tag;
  logic [TAG_BITS-1:0]      w_mis_age;
  logic [31:0]              w_mis_pc;

  logic [MAX_BRANCH_IF-1:0] w_done_pre;
  logic [MAX_BRANCH_IF-1:0] w_done_next;
  logic [TAG_BITS-1:0]      w_ent_age;
  logic [TAG_BITS-1:0]      w_ent_idx;
  logic [CNT_BITS-1:0]      w_live_cnt;
  logic [CNT_BITS-1:0]      w_alloc_cnt;
  logic [CNT_BITS-1:0]      w_retire;
  logic                     w_stop;
  logic [TAG_BITS-1:0]      w_tail_next;
  logic [TAG_BITS-1:0]      w_head_next;
  logic [CNT_BITS-1:0]      w_count_next;

  // Decode side: count requested branches, accept the whole group only if they all fit, hand out per-lane tags
  always_comb begin
    w_nb        = 0;
    w_run       = r_tail - TAG_BITS'(1);
    w_alloc_tag = '0;
    for (int l = 0; l < DECODE_WIDTH; l++) begin
      if (dec_valid_i[l] && dec_is_branch_i[l]) begin
        w_nb  = w_nb + 1;
        w_run = w_run + TAG_BITS'(1);
      end
      w_alloc_tag[l*TAG_BITS +: TAG_BITS] = w_run;
    end
    w_ready = (w_nb <= (MAX_BRANCH_IF - int'(r_count)));
    w_fire  = w_ready && (|dec_valid_i);
  end

  // Resolve side: collect correct resolves on live tags and pick the oldest live mispredict
  always_comb begin
    w_res_tag   = '0;
    w_res_age   = '0;
    w_done_set  = '0;
    w_mis_valid = 1'b0;
    w_mis_tag   = '0;
    w_mis_age   = '0;
    w_mis_pc    = '0;
    for (int p = 0; p < RESOLVE_PORTS; p++) begin
      w_res_tag = res_tag_i[p*TAG_BITS +: TAG_BITS];
      w_res_age = w_res_tag - r_head;
      if (res_valid_i[p] && ({1'b0, w_res_age} < r_count)) begin
        if (res_mispredict_i[p]) begin
          if (!w_mis_valid || (w_res_age < w_mis_age)) begin
            w_mis_valid = 1'b1;
            w_mis_tag   = w_res_tag;
            w_mis_age   = w_res_age;
            w_mis_pc    = res_target_i[p*32 +: 32];
          end
        end else begin
          w_done_set[w_res_tag] = 1'b1;
        end
      end
    end
  end

  // Ring update: apply mispredict truncation or allocation, then retire the contiguous done prefix from head
  always_comb begin
    w_done_pre = r_done | w_done_set;
    w_ent_age  = '0;
    if (w_mis_valid) begin
      w_done_pre[w_mis_tag] = 1'b1;
      for (int e = 0; e < MAX_BRANCH_IF; e++) begin
        w_ent_age = TAG_BITS'(e) - r_head;
        if (w_ent_age > w_mis_age) begin
          w_done_pre[e] = 1'b0;
        end
      end
      w_live_cnt  = {1'b0, w_mis_age} + CNT_BITS'(1);
      w_tail_next = w_mis_tag + TAG_BITS'(1);
      w_alloc_cnt = '0;
    end else begin
      w_live_cnt  = r_count;
      w_tail_next = w_fire ? (r_tail + TAG_BITS'(w_nb)) : r_tail;
      w_alloc_cnt = w_fire ? CNT_BITS'(w_nb) : '0;
    end
    w_done_next = w_done_pre;
    w_retire    = '0;
    w_stop      = 1'b0;
    w_ent_idx   = '0;
    for (int i = 0; i < MAX_BRANCH_IF; i++) begin
      w_ent_idx = r_head + TAG_BITS'(i);
      if (!w_stop && (CNT_BITS'(i) < w_live_cnt) && w_done_pre[w_ent_idx]) begin
        w_done_next[w_ent_idx] = 1'b0;
        w_retire               = w_retire + CNT_BITS'(1);
      end else begin
        w_stop = 1'b1;
      end
    end
    w_head_next  = r_head + w_retire[TAG_BITS-1:0];
    w_count_next = w_live_cnt - w_retire + w_alloc_cnt;
  end

  // State registers; external flush empties the ring and suppresses any redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_done      <= '0;
      r_flush     <= 1'b0;
      r_flush_pc  <= '0;
      r_flush_tag <= '0;
    end else if (ext_flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_done  <= '0;
      r_flush <= 1'b0;
    end else begin
      r_head  <= w_head_next;
      r_tail  <= w_tail_next;
      r_count <= w_count_next;
      r_done  <= w_done_next;
      r_flush <= w_mis_valid;
      if (w_mis_valid) begin
        r_flush_pc  <= w_mis_pc;
        r_flush_tag <= w_mis_tag;
      end
    end
  end

  assign dec_ready_o = w_ready;
  assign alloc_tag_o = w_alloc_tag;
  assign flush_o     = r_flush;
  assign flush_pc_o  = r_flush_pc;
  assign flush_tag_o = r_flush_tag;
  assign inflight_o  = r_count;
  assign full_o      = (r_count == CNT_BITS'(MAX_BRANCH_IF));

endmodule

// File: tb/tb_branch_tag_allocator.sv
// tb/tb_branch_tag_allocator.sv - scoreboard bench for branch_tag_allocator at default parameters
module tb_branch_tag_allocator;

  localparam int DW = 2;
  localparam int MB = 4;
  localparam int RP = 2;
  localparam int TB = 2;
  localparam int CB = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [DW-1:0]   dec_valid_i = '0;
  logic [DW-1:0]   dec_is_branch_i = '0;
  logic            dec_ready_o;
  logic [DW*TB-1:0] alloc_tag_o;
  logic [RP-1:0]   res_valid_i = '0;
  logic [RP*TB-1:0] res_tag_i = '0;
  logic [RP-1:0]   res_mispredict_i = '0;
  logic [RP*32-1:0] res_target_i = '0;
  logic            ext_flush_i = 1'b0;
  logic            flush_o;
  logic [31:0]     flush_pc_o;
  logic [TB-1:0]   flush_tag_o;
  logic [CB-1:0]   inflight_o;
  logic            full_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [TB-1:0] exp_tag_q[$];
  logic [TB-1:0] exp_ftag_q[$];
  logic [31:0]   exp_fpc_q[$];

  branch_tag_allocator #(.DECODE_WIDTH(DW), .MAX_BRANCH_IF(MB), .RESOLVE_PORTS(RP)) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid_i(dec_valid_i), .dec_is_branch_i(dec_is_branch_i),
    .dec_ready_o(dec_ready_o), .alloc_tag_o(alloc_tag_o),
    .res_valid_i(res_valid_i), .res_tag_i(res_tag_i),
    .res_mispredict_i(res_mispredict_i), .res_target_i(res_target_i),
    .ext_flush_i(ext_flush_i),
    .flush_o(flush_o), .flush_pc_o(flush_pc_o), .flush_tag_o(flush_tag_o),
    .inflight_o(inflight_o), .full_o(full_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    dec_valid_i      = '0;
    dec_is_branch_i  = '0;
    res_valid_i      = '0;
    res_tag_i        = '0;
    res_mispredict_i = '0;
    res_target_i     = '0;
    ext_flush_i      = 1'b0;
  endtask

  task automatic set_dec(input logic [DW-1:0] v, input logic [DW-1:0] b);
    dec_valid_i     = v;
    dec_is_branch_i = b;
  endtask

  task automatic set_res(input int p, input logic [TB-1:0] t, input logic mis, input logic [31:0] pc);
    res_valid_i[p]         = 1'b1;
    res_tag_i[p*TB +: TB]  = t;
    res_mispredict_i[p]    = mis;
    res_target_i[p*32 +: 32] = pc;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [TB-1:0] e;
    clr_inputs();
    rst_n = 1'b0;
    #3;
    n_tests++; if (inflight_o !== 3'd0) begin n_fail++; $display("FAIL rst_inflight got %0d want 0", inflight_o); end
    n_tests++; if (full_o !== 1'b0) begin n_fail++; $display("FAIL rst_full got %0b want 0", full_o); end
    n_tests++; if (flush_o !== 1'b0 || flush_pc_o !== 32'h0 || flush_tag_o !== 2'd0) begin
      n_fail++; $display("FAIL rst_flush got %0b/%h/%0d want 0/0/0", flush_o, flush_pc_o, flush_tag_o);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_dec(2'b11, 2'b00);
    exp_tag_q.push_back(2'd3);
    exp_tag_q.push_back(2'd3);
    #1;
    n_tests++; if (dec_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %0b want 1", dec_ready_o); end
    for (int l = 0; l < DW; l++) begin
      e = exp_tag_q.pop_front();
      n_tests++; if (alloc_tag_o[l*TB +: TB] !== e) begin n_fail++; $display("FAIL rst_nb_tag lane%0d got %0d want %0d", l, alloc_tag_o[l*TB +: TB], e); end
    end
    clr_inputs();
    tick();
  endtask

  // Fill the ring with two full branch groups; also used as setup by later tests.
  task automatic test_fill(input string nm);
    logic [TB-1:0] e;
    for (int g = 0; g < 2; g++) begin
      set_dec(2'b11, 2'b11);
      exp_tag_q.push_back(TB'(2*g));
      exp_tag_q.push_back(TB'(2*g+1));
      #1;
      n_tests++; if (dec_ready_o !== 1'b1) begin n_fail++; $display("FAIL %s_ready g%0d got %0b want 1", nm, g, dec_ready_o); end
      for (int l = 0; l < DW; l++) begin
        e = exp_tag_q.pop_front();
        n_tests++; if (alloc_tag_o[l*TB +: TB] !== e) begin n_fail++; $display("FAIL %s_tag g%0d lane%0d got %0d want %0d", nm, g, l, alloc_tag_o[l*TB +: TB], e); end
      end
      tick();
    end
    clr_inputs();
    #1;
    n_tests++; if (inflight_o !== 3'd4 || full_o !== 1'b1) begin n_fail++; $display("FAIL %s_full got cnt %0d full %0b want 4/1", nm, inflight_o, full_o); end
  endtask

  task automatic test_alloc();
    do_reset();
    test_fill("alloc");
    set_dec(2'b11, 2'b11);
    #1;
    n_tests++; if (dec_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_block got %0b want 0", dec_ready_o); end
    set_dec(2'b11, 2'b00);
    #1;
    n_tests++; if (dec_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_nonbranch got %0b want 1", dec_ready_o); end
    set_dec(2'b01, 2'b01);
    #1;
    n_tests++; if (dec_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_one got %0b want 0", dec_ready_o); end
    clr_inputs();
    tick();
    n_tests++; if (inflight_o !== 3'd4) begin n_fail++; $display("FAIL full_hold got %0d want 4", inflight_o); end
  endtask

  task automatic test_retire();
    set_res(0, 2'd1, 1'b0, 32'h0);
    tick(); clr_inputs();
    n_tests++; if (inflight_o !== 3'd4) begin n_fail++; $display("FAIL retire_ooo got %0d want 4", inflight_o); end
    set_res(0, 2'd0, 1'b0, 32'h0);
    tick(); clr_inputs();
    n_tests++; if (inflight_o !== 3'd2 || full_o !== 1'b0) begin n_fail++; $display("FAIL retire_two got %0d/%0b want 2/0", inflight_o, full_o); end
    set_res(0, 2'd0, 1'b0, 32'h0);
    tick(); clr_inputs();
    n_tests++; if (inflight_o !== 3'd2) begin n_fail++; $display("FAIL retire_stale got %0d want 2", inflight_o); end
    set_res(0, 2'd2, 1'b0, 32'h0);
    set_res(1, 2'd2, 1'b0, 32'h0);
    tick(); clr_inputs();
    n_tests++; if (inflight_o !== 3'd1) begin n_fail++; $display("FAIL retire_dup got %0d want 1", inflight_o); end
    set_res(1, 2'd3, 1'b0, 32'h0);
    tick(); clr_inputs();
    n_tests++; if (inflight_o !== 3'd0) begin n_fail++; $display("FAIL retire_last got %0d want 0", inflight_o); end
  endtask

  task automatic test_mispredict();
    logic [TB-1:0] et;
    logic [31:0]   ep;
    do_reset();
    test_fill("mis");
    set_res(0, 2'd2, 1'b1, 32'h100);
    set_res(1, 2'd1, 1'b1, 32'h200);
    exp_ftag_q.push_back(2'd1); exp_fpc_q.push_back(32'h200);
    tick(); clr_inputs();
    n_tests++; if (inflight_o !== 3'd2) begin n_fail++; $display("FAIL mis_count got %0d want 2", inflight_o); end
    n_tests++;
    if (flush_o !== 1'b1 || exp_ftag_q.size() == 0) begin
      n_fail++; $display("FAIL mis_flush got %0b want 1", flush_o);
    end else begin
      et = exp_ftag_q.pop_front(); ep = exp_fpc_q.pop_front();
      n_tests++; if (flush_pc_o !== ep) begin n_fail++; $display("FAIL mis_pc got %h want %h", flush_pc_o, ep); end
      n_tests++; if (flush_tag_o !== et) begin n_fail++; $display("FAIL mis_tag got %0d want %0d", flush_tag_o, et); end
    end
    set_dec(2'b01, 2'b00);
    #1;
    n_tests++; if (alloc_tag_o[TB-1:0] !== 2'd1) begin n_fail++; $display("FAIL mis_tail got %0d want 1", alloc_tag_o[TB-1:0]); end
    clr_inputs();
    tick();
    n_tests++; if (flush_o !== 1'b0) begin n_fail++; $display("FAIL mis_oneshot got %0b want 0", flush_o); end
    set_dec(2'b01, 2'b01);
    set_res(0, 2'd1, 1'b1, 32'h300);
    exp_ftag_q.push_back(2'd1); exp_fpc_q.push_back(32'h300);
    #1;
    n_tests++; if (dec_ready_o !== 1'b1 || alloc_tag_o[TB-1:0] !== 2'd2) begin
      n_fail++; $display("FAIL mis_fire_comb got rdy %0b tag %0d want 1/2", dec_ready_o, alloc_tag_o[TB-1:0]);
    end
    tick(); clr_inputs();
    n_tests++; if (inflight_o !== 3'd2) begin n_fail++; $display("FAIL mis_discard got %0d want 2", inflight_o); end
    n_tests++;
    if (flush_o !== 1'b1 || exp_ftag_q.size() == 0) begin
      n_fail++; $display("FAIL mis2_flush got %0b want 1", flush_o);
    end else begin
      et = exp_ftag_q.pop_front(); ep = exp_fpc_q.pop_front();
      n_tests++; if (flush_pc_o !== ep || flush_tag_o !== et) begin n_fail++; $display("FAIL mis2_redirect got %h/%0d want %h/%0d", flush_pc_o, flush_tag_o, ep, et); end
    end
    set_dec(2'b01, 2'b00);
    #1;
    n_tests++; if (alloc_tag_o[TB-1:0] !== 2'd1) begin n_fail++; $display("FAIL mis2_tail got %0d want 1", alloc_tag_o[TB-1:0]); end
    clr_inputs();
    tick();
  endtask

  // Bring the ring to head 0, tail 3, count 3 from reset.
  task automatic setup_three(input string nm);
    logic [TB-1:0] e;
    do_reset();
    set_dec(2'b11, 2'b11);
    exp_tag_q.push_back(2'd0); exp_tag_q.push_back(2'd1);
    #1;
    for (int l = 0; l < DW; l++) begin
      e = exp_tag_q.pop_front();
      n_tests++; if (alloc_tag_o[l*TB +: TB] !== e) begin n_fail++; $display("FAIL %s_s1 lane%0d got %0d want %0d", nm, l, alloc_tag_o[l*TB +: TB], e); end
    end
    tick();
    set_dec(2'b01, 2'b01);
    exp_tag_q.push_back(2'd2);
    #1;
    e = exp_tag_q.pop_front();
    n_tests++; if (alloc_tag_o[TB-1:0] !== e) begin n_fail++; $display("FAIL %s_s2 got %0d want %0d", nm, alloc_tag_o[TB-1:0], e); end
    tick(); clr_inputs();
    n_tests++; if (inflight_o !== 3'd3) begin n_fail++; $display("FAIL %s_cnt3 got %0d want 3", nm, inflight_o); end
  endtask

  task automatic test_nonbranch();
    logic [TB-1:0] e;
    setup_three("nbA");
    set_dec(2'b11, 2'b01);
    exp_tag_q.push_back(2'd3); exp_tag_q.push_back(2'd3);
    #1;
    for (int l = 0; l < DW; l++) begin
      e = exp_tag_q.pop_front();
      n_tests++; if (alloc_tag_o[l*TB +: TB] !== e) begin n_fail++; $display("FAIL nb_br_first lane%0d got %0d want %0d", l, alloc_tag_o[l*TB +: TB], e); end
    end
    tick(); clr_inputs();
    n_tests++; if (inflight_o !== 3'd4) begin n_fail++; $display("FAIL nb_cntA got %0d want 4", inflight_o); end
    setup_three("nbB");
    set_dec(2'b11, 2'b10);
    exp_tag_q.push_back(2'd2); exp_tag_q.push_back(2'd3);
    #1;
    for (int l = 0; l < DW; l++) begin
      e = exp_tag_q.pop_front();
      n_tests++; if (alloc_tag_o[l*TB +: TB] !== e) begin n_fail++; $display("FAIL nb_nb_first lane%0d got %0d want %0d", l, alloc_tag_o[l*TB +: TB], e); end
    end
    tick(); clr_inputs();
    n_tests++; if (inflight_o !== 3'd4) begin n_fail++; $display("FAIL nb_cntB got %0d want 4", inflight_o); end
  endtask

  task automatic test_wrap();
    logic [TB-1:0] e;
    setup_three("wrap");
    set_res(0, 2'd0, 1'b0, 32'h0);
    set_res(1, 2'd1, 1'b0, 32'h0);
    tick(); clr_inputs();
    n_tests++; if (inflight_o !== 3'd1) begin n_fail++; $display("FAIL wrap_cnt1 got %0d want 1", inflight_o); end
    set_dec(2'b11, 2'b11);
    set_res(0, 2'd2, 1'b0, 32'h0);
    exp_tag_q.push_back(2'd3); exp_tag_q.push_back(2'd0);
    #1;
    n_tests++; if (dec_ready_o !== 1'b1) begin n_fail++; $display("FAIL wrap_ready got %0b want 1", dec_ready_o); end
    for (int l = 0; l < DW; l++) begin
      e = exp_tag_q.pop_front();
      n_tests++; if (alloc_tag_o[l*TB +: TB] !== e) begin n_fail++; $display("FAIL wrap_tag lane%0d got %0d want %0d", l, alloc_tag_o[l*TB +: TB], e); end
    end
    tick(); clr_inputs();
    n_tests++; if (inflight_o !== 3'd2) begin n_fail++; $display("FAIL wrap_cnt got %0d want 2", inflight_o); end
    set_dec(2'b01, 2'b00);
    #1;
    n_tests++; if (alloc_tag_o[TB-1:0] !== 2'd0) begin n_fail++; $display("FAIL wrap_tail got %0d want 0", alloc_tag_o[TB-1:0]); end
    clr_inputs();
    tick();
  endtask

  task automatic test_ext_flush();
    logic [TB-1:0] e;
    logic [TB-1:0] et;
    logic [31:0]   ep;
    do_reset();
    test_fill("xf");
    ext_flush_i = 1'b1;
    set_res(0, 2'd0, 1'b1, 32'h40);
    set_dec(2'b01, 2'b01);
    tick(); clr_inputs();
    n_tests++; if (inflight_o !== 3'd0 || full_o !== 1'b0) begin n_fail++; $display("FAIL xf_count got %0d/%0b want 0/0", inflight_o, full_o); end
    n_tests++; if (flush_o !== 1'b0) begin n_fail++; $display("FAIL xf_noflush got %0b want 0", flush_o); end
    tick();
    n_tests++; if (flush_o !== 1'b0) begin n_fail++; $display("FAIL xf_noflush2 got %0b want 0", flush_o); end
    set_dec(2'b01, 2'b01);
    exp_tag_q.push_back(2'd0);
    #1;
    e = exp_tag_q.pop_front();
    n_tests++; if (alloc_tag_o[TB-1:0] !== e) begin n_fail++; $display("FAIL xf_tail got %0d want %0d", alloc_tag_o[TB-1:0], e); end
    tick(); clr_inputs();
    set_res(0, 2'd0, 1'b1, 32'h80);
    exp_ftag_q.push_back(2'd0); exp_fpc_q.push_back(32'h80);
    tick(); clr_inputs();
    n_tests++;
    if (flush_o !== 1'b1 || exp_ftag_q.size() == 0) begin
      n_fail++; $display("FAIL xf_preflush got %0b want 1", flush_o);
    end else begin
      et = exp_ftag_q.pop_front(); ep = exp_fpc_q.pop_front();
      n_tests++; if (flush_pc_o !== ep || flush_tag_o !== et) begin n_fail++; $display("FAIL xf_redirect got %h/%0d want %h/%0d", flush_pc_o, flush_tag_o, ep, et); end
    end
    rst_n = 1'b0;
    #1;
    n_tests++; if (flush_o !== 1'b0 || flush_pc_o !== 32'h0 || flush_tag_o !== 2'd0) begin
      n_fail++; $display("FAIL midrst_flush got %0b/%h/%0d want 0/0/0", flush_o, flush_pc_o, flush_tag_o);
    end
    n_tests++; if (inflight_o !== 3'd0 || full_o !== 1'b0 || dec_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL midrst_state got %0d/%0b/%0b want 0/0/1", inflight_o, full_o, dec_ready_o);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_retire();
    test_mispredict();
    test_nonbranch();
    test_wrap();
    test_ext_flush();
    n_tests++; if (exp_tag_q.size() != 0 || exp_ftag_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain got %0d/%0d want 0/0", exp_tag_q.size(), exp_ftag_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
